fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program-ROM address bus.
- Maintains the program counter and compensates for the ROM's one-cycle synchronous read latency.
- Presents fetched words to decode through a valid/ready handshake; accepts branch/jump redirects from the control unit.
- Stops fetching after handing off a HALT instruction.

Parameters:
- DATA_WIDTH, 32, instruction word width (matches program ROM).
- ADDR_WIDTH, 9, ROM address width; PC wraps modulo 2**ADDR_WIDTH.
- START_ADDR, 1, first address fetched after reset.
- OPCODE_MSB, 31, upper bit of the opcode field.
- OPCODE_LSB, 26, lower bit of the opcode field.
- HALT_OPCODE, 6'b010001, opcode that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_WIDTH  address to program ROM; combinational from state and inputs.
- rom_q  in  DATA_WIDTH  ROM read data; holds ROM[address issued previous cycle].
- instr  out  DATA_WIDTH  instruction to decode (rom_q passed through).
- instr_pc  out  ADDR_WIDTH  address of instr.
- instr_valid  out  1  instr/instr_pc valid this cycle.
- instr_ready  in  1  decode accepts; handoff = instr_valid && instr_ready.
- redirect  in  1  branch/jump taken this cycle.
- redirect_addr  in  ADDR_WIDTH  redirect target.
- halted  out  1  high while in HALTED.

Behaviour:
- One clock; reset is synchronous and active-high on `reset`, sampled at the rising edge of `clk`.
- State register: BOOT, RUN, HALTED. Register fetch_pc holds the address issued last cycle.
- Reset, with priority over everything: state=BOOT, fetch_pc=START_ADDR. During and after reset: instr_valid=0, halted=0, instr_pc=START_ADDR.
- BOOT (exactly one cycle):
  - rom_addr=fetch_pc; instr_valid=0.
  - Next state RUN; fetch_pc unchanged.
  - If redirect is high: rom_addr=redirect_addr and fetch_pc<=redirect_addr.
- RUN:
  - instr_valid = !redirect; instr=rom_q; instr_pc=fetch_pc.
  - Advance when instr_valid && instr_ready.
  - Priority of rom_addr:
    1. redirect: rom_addr=redirect_addr.
    2. advance and opcode != HALT_OPCODE: rom_addr=fetch_pc+1, wrapping 2**ADDR_WIDTH-1 -> 0.
    3. Otherwise: rom_addr=fetch_pc, re-issued so rom_q stays stable while decode stalls.
  - fetch_pc<=rom_addr every cycle.
  - Latency: redirect in cycle t -> instr_valid=1 with instr=ROM[redirect_addr] in cycle t+1.
  - Back-to-back handoffs sustain one instruction per cycle.
- Halt:
  - Handoff of a word whose instr[OPCODE_MSB:OPCODE_LSB]==HALT_OPCODE moves state to HALTED next cycle.
  - rom_addr holds fetch_pc, so the HALT word itself is consumed exactly once.
- HALTED:
  - instr_valid=0; halted=1; rom_addr=fetch_pc.
  - Ignores instr_ready.
  - redirect: rom_addr=redirect_addr, fetch_pc<=redirect_addr, state -> RUN, halted=0 next cycle.
- Simultaneous redirect and handoff in RUN: redirect wins; instr_valid is 0 that cycle, so no handoff occurs and the presented word is dropped.
- A HALT word presented in the same cycle as redirect is dropped and does not halt.
- Reset mid-stall or mid-redirect: all pending state is discarded and the sequence restarts from BOOT.
- No arithmetic other than the PC increment; all addresses are ADDR_WIDTH bits, unsigned, with silent wrap.

Decomposition:
- Shared package:
  - State encoding (BOOT=2'd0, RUN=2'd1, HALTED=2'd2).
  - OPCODE_MSB/OPCODE_LSB.
  - HALT_OPCODE and other opcode constants, shared with the decoder.
- No sub-module needed; a single always block for state/fetch_pc plus combinational next-address logic.

Test Plan:
- Reset, then instr_ready=1, ROM[1..6] preloaded:
  - rom_addr=1 in the BOOT cycle.
  - instr_valid rises the cycle after BOOT with instr_pc=1.
  - instr_pc then steps 1,2,3,4,5,6 on consecutive cycles.
  - The word at 6 (opcode 010001) causes halted=1 the next cycle and instr_valid=0 thereafter.
- instr_ready=0 for 3 cycles while instr_pc=3:
  - instr, instr_pc=3 and rom_addr=3 stay constant.
  - After release, the next presented instr_pc=4 with no word skipped or duplicated.
- redirect=1, redirect_addr=2 while instr_pc=4 and instr_ready=1:
  - The word at 4 is not handed off.
  - The next cycle presents instr_pc=2, instr=ROM[2].
- fetch_pc=511 (ADDR_WIDTH=9) with handoff: rom_addr=0 and the next instr_pc=0.
- In HALTED, redirect with redirect_addr=1: halted falls, the next cycle has instr_valid=1 and instr_pc=1; instr_ready pulses during HALTED have no effect.
- Assert reset during a stall at instr_pc=5: the cycle after reset has instr_valid=0 and rom_addr=1, then the sequence restarts at instr_pc=1.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch/decode constants: sequencer states
// and the opcode field layout used by the decoder.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;

  localparam logic [5:0] OP_NOP      = 6'b000000;
  localparam logic [5:0] OP_JUMP     = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] HALT_OPCODE = 6'b010001;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the ROM address bus, hides the
// one-cycle ROM latency and hands words to decode.
module fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int START_ADDR = 1,
  parameter int OPCODE_MSB = fetch_sequencer_pkg::OPCODE_MSB,
  parameter int OPCODE_LSB = fetch_sequencer_pkg::OPCODE_LSB,
  parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE =
    fetch_sequencer_pkg::HALT_OPCODE
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  halted
);
  import fetch_sequencer_pkg::*;

  localparam logic [ADDR_WIDTH-1:0] START =
    ADDR_WIDTH'(START_ADDR);

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic                  is_halt;
  logic                  advance;

  assign pc_inc  = fetch_pc + ADDR_WIDTH'(1);
  assign is_halt = rom_q[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;

  assign instr       = rom_q;
  assign instr_pc    = reset ? START : fetch_pc;
  assign instr_valid = !reset && state == RUN && !redirect;
  assign halted      = !reset && state == HALTED;
  assign advance     = instr_valid && instr_ready;

  // Re-issuing fetch_pc keeps rom_q stable across stalls and after HALT
  always_comb begin
    rom_addr = fetch_pc;
    unique case (1'b1)
      redirect:            rom_addr = redirect_addr;
      advance && !is_halt: rom_addr = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      fetch_pc <= START;
    end else begin
      fetch_pc <= rom_addr;
      unique case (state)
        BOOT:    state <= RUN;
        RUN:     if (advance && is_halt) state <= HALTED;
        HALTED:  if (redirect) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
